// File: rtl/square_pkg.sv
// Shared types and default geometry for the square game engine.
package square_pkg;

  // Controller states; encoding is arbitrary, IDLE must stay at zero for reset clarity.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PULSE      = 3'd1,
    WAIT_EOC   = 3'd2,
    WAIT_FRAME = 3'd3,
    GAME_OVER  = 3'd4
  } state_t;

  // Default playfield geometry in pixels.
  localparam int SCREEN_W    = 640;
  localparam int SQUARE_DIM  = 50;
  localparam int CENTER_X    = 270;
  localparam int LEFT_LIMIT  = 160;
  localparam int RIGHT_LIMIT = 430;

endpackage

// File: rtl/adc_handshake.sv
// ADC conversion handshake: generates the fixed-width start pulse, waits for
// end-of-conversion with a bounded timeout, and captures the sample at eoc.
module adc_handshake #(
  parameter int START_PULSE = 11,
  parameter int EOC_TIMEOUT = 4096,
  parameter int SPEED_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               launch,
  input  logic               abort,
  input  logic               in_pulse,
  input  logic               in_wait,
  input  logic               eoc,
  input  logic [SPEED_W-1:0] sample_in,
  output logic               adc_start,
  output logic               pulse_done,
  output logic               sample_valid,
  output logic               timeout,
  output logic [SPEED_W-1:0] sample
);

  localparam int PC_W = $clog2(START_PULSE + 1);
  localparam int TC_W = $clog2(EOC_TIMEOUT + 1);

  logic [PC_W-1:0] pulse_cnt;
  logic [TC_W-1:0] tmo_cnt;

  // Terminal counts are qualified by the phase so stale counter values never leak out.
  assign pulse_done   = in_pulse && (pulse_cnt == '0);
  assign sample_valid = in_wait && eoc;
  assign timeout      = in_wait && !eoc && (tmo_cnt == '0);

  // Pulse width down-counter, loaded when a conversion is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
    end else if (launch) begin
      pulse_cnt <= PC_W'(START_PULSE - 1);
    end else if (in_pulse && (pulse_cnt != '0)) begin
      pulse_cnt <= pulse_cnt - 1'b1;
    end
  end

  // EOC timeout down-counter, loaded as the start pulse ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (pulse_done) begin
      tmo_cnt <= TC_W'(EOC_TIMEOUT - 1);
    end else if (in_wait && (tmo_cnt != '0)) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  // Registered start request; abort wins so a game stop drops it on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_start <= 1'b0;
    end else if (abort) begin
      adc_start <= 1'b0;
    end else if (launch) begin
      adc_start <= 1'b1;
    end else if (pulse_done) begin
      adc_start <= 1'b0;
    end
  end

  // Sample is frozen at eoc so the move uses the value the ADC actually reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
    end else if (sample_valid) begin
      sample <= sample_in;
    end
  end

endmodule

// File: rtl/square_game_engine.sv
// Two-player square game: alternating ADC samples push the square left or
// right once per frame; crossing a goal line scores and recentres the square.
//
// state      | meaning
// IDLE       | waiting for a fresh startGame rising edge
// PULSE      | adc_start asserted for START_PULSE cycles
// WAIT_EOC   | waiting for eoc, retry pulse after EOC_TIMEOUT cycles
// WAIT_FRAME | sample held, move applied on the next screenEnd
// GAME_OVER  | a player reached MAX_SCORE, everything frozen
module square_game_engine #(
  parameter int SCREEN_W    = square_pkg::SCREEN_W,
  parameter int SQUARE_DIM  = square_pkg::SQUARE_DIM,
  parameter int CENTER_X    = square_pkg::CENTER_X,
  parameter int LEFT_LIMIT  = square_pkg::LEFT_LIMIT,
  parameter int RIGHT_LIMIT = square_pkg::RIGHT_LIMIT,
  parameter int SPEED_W     = 8,
  parameter int SPEED_SHIFT = 5,
  parameter int START_PULSE = 11,
  parameter int EOC_TIMEOUT = 4096,
  parameter int SCORE_W     = 8,
  parameter int MAX_SCORE   = 9,
  localparam int X_W        = $clog2(SCREEN_W)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               screenEnd,
  input  logic               startGame,
  input  logic               eoc,
  input  logic [SPEED_W-1:0] moveSpeed,
  output logic               adc_start,
  output logic               player,
  output logic [X_W-1:0]     squareX,
  output logic [SCORE_W-1:0] leftScore,
  output logic [SCORE_W-1:0] rightScore,
  output logic               gameOver,
  output logic               winner,
  output logic               busy
);

  // Position arithmetic needs one bit of headroom over the wider operand.
  localparam int SUM_W = ((X_W > SPEED_W) ? X_W : SPEED_W) + 1;

  localparam logic [SUM_W-1:0]   X_MAX   = SUM_W'(SCREEN_W - SQUARE_DIM);
  localparam logic [SUM_W-1:0]   LEFT_L  = SUM_W'(LEFT_LIMIT);
  localparam logic [SUM_W-1:0]   RIGHT_L = SUM_W'(RIGHT_LIMIT);
  localparam logic [X_W-1:0]     CX      = X_W'(CENTER_X);
  localparam logic [SCORE_W-1:0] MAX_V   = SCORE_W'(MAX_SCORE);

  square_pkg::state_t state, state_n;

  logic               start_prev, start_armed, start_rise;
  logic               launch, abort;
  logic               pulse_done, sample_valid, timeout;
  logic [SPEED_W-1:0] sample, step;
  logic [SUM_W-1:0]   x_ext, step_ext, sum, moved;
  logic               hit_left, hit_right;

  logic [X_W-1:0]     x_n;
  logic               player_n, over_n, win_n;
  logic [SCORE_W-1:0] ls_n, rs_n;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
  endfunction

  adc_handshake #(
    .START_PULSE (START_PULSE),
    .EOC_TIMEOUT (EOC_TIMEOUT),
    .SPEED_W     (SPEED_W)
  ) u_adc (
    .clk          (clk),
    .rst_n        (reset),
    .launch       (launch),
    .abort        (abort),
    .in_pulse     (state == square_pkg::PULSE),
    .in_wait      (state == square_pkg::WAIT_EOC),
    .eoc          (eoc),
    .sample_in    (moveSpeed),
    .adc_start    (adc_start),
    .pulse_done   (pulse_done),
    .sample_valid (sample_valid),
    .timeout      (timeout),
    .sample       (sample)
  );

  // A level already high when reset releases must first be seen low before it can start a game.
  assign start_rise = startGame && !start_prev && start_armed;

  assign step     = sample >> SPEED_SHIFT;
  assign x_ext    = SUM_W'(squareX);
  assign step_ext = SUM_W'(step);
  assign sum      = x_ext + step_ext;

  // Candidate position with clamping at both screen edges.
  always_comb begin
    moved = x_ext;
    if (!player) begin
      moved = (sum > X_MAX) ? X_MAX : sum;
    end else begin
      moved = (step_ext > x_ext) ? '0 : x_ext - step_ext;
    end
  end

  assign hit_left  = moved < LEFT_L;
  assign hit_right = moved > RIGHT_L;

  // Next-state and datapath decisions; startGame low outranks every other event.
  always_comb begin
    state_n  = state;
    x_n      = squareX;
    player_n = player;
    ls_n     = leftScore;
    rs_n     = rightScore;
    over_n   = gameOver;
    win_n    = winner;
    launch   = 1'b0;
    abort    = 1'b0;
    if ((state != square_pkg::IDLE) && !startGame) begin
      state_n = square_pkg::IDLE;
      abort   = 1'b1;
    end else begin
      case (state)
        square_pkg::IDLE: begin
          if (start_rise) begin
            ls_n     = '0;
            rs_n     = '0;
            x_n      = CX;
            player_n = 1'b0;
            over_n   = 1'b0;
            win_n    = 1'b0;
            launch   = 1'b1;
            state_n  = square_pkg::PULSE;
          end
        end
        square_pkg::PULSE: begin
          if (pulse_done) state_n = square_pkg::WAIT_EOC;
        end
        square_pkg::WAIT_EOC: begin
          if (sample_valid) begin
            state_n = square_pkg::WAIT_FRAME;
          end else if (timeout) begin
            launch  = 1'b1;
            state_n = square_pkg::PULSE;
          end
        end
        square_pkg::WAIT_FRAME: begin
          if (screenEnd) begin
            player_n = ~player;
            x_n      = X_W'(moved);
            launch   = 1'b1;
            state_n  = square_pkg::PULSE;
            if (hit_left) begin
              x_n  = CX;
              rs_n = sat_inc(rightScore);
              if (rs_n == MAX_V) begin
                over_n  = 1'b1;
                win_n   = 1'b1;
                launch  = 1'b0;
                state_n = square_pkg::GAME_OVER;
              end
            end else if (hit_right) begin
              x_n  = CX;
              ls_n = sat_inc(leftScore);
              if (ls_n == MAX_V) begin
                over_n  = 1'b1;
                win_n   = 1'b0;
                launch  = 1'b0;
                state_n = square_pkg::GAME_OVER;
              end
            end
          end
        end
        square_pkg::GAME_OVER: begin
          state_n = square_pkg::GAME_OVER;
        end
        default: begin
          state_n = square_pkg::IDLE;
        end
      endcase
    end
  end

  // startGame history used for edge detection and post-reset arming.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_prev  <= 1'b0;
      start_armed <= 1'b0;
    end else begin
      start_prev  <= startGame;
      start_armed <= start_armed | ~startGame;
    end
  end

  // Architectural state and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= square_pkg::IDLE;
      squareX    <= CX;
      player     <= 1'b0;
      leftScore  <= '0;
      rightScore <= '0;
      gameOver   <= 1'b0;
      winner     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      squareX    <= x_n;
      player     <= player_n;
      leftScore  <= ls_n;
      rightScore <= rs_n;
      gameOver   <= over_n;
      winner     <= win_n;
      busy       <= (state_n != square_pkg::IDLE);
    end
  end

endmodule

// File: tb/tb_square_game_engine.sv
// Bench for square_game_engine: a game-rule model checked every cycle, plus
// directed scenarios with hand-computed results, then randomized play.
module tb_square_game_engine;

  localparam int START_PULSE = 11;
  localparam int EOC_TIMEOUT = 4096;
  localparam int CENTER      = 270;
  localparam int LEFT_LIM    = 160;
  localparam int RIGHT_LIM   = 430;
  localparam int X_MAX       = 590;
  localparam int MAX_SCORE   = 9;
  localparam int SHIFT       = 5;

  // model phases (bench-private naming)
  localparam int P_IDLE = 0, P_PULSE = 1, P_WAIT = 2, P_FRAME = 3, P_OVER = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       screenEnd = 1'b0;
  logic       startGame = 1'b0;
  logic       eoc = 1'b0;
  logic [7:0] moveSpeed = 8'd0;

  logic       adc_start, player, gameOver, winner, busy;
  logic [9:0] squareX;
  logic [7:0] leftScore, rightScore;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  bit chk_en = 1'b0;

  int m_phase, m_elapsed, m_x, m_player, m_ls, m_rs, m_over, m_win, m_adc;
  int m_prev, m_armed, m_sample;

  always #5 clk = ~clk;

  square_game_engine dut (
    .clk        (clk),
    .reset      (reset),
    .screenEnd  (screenEnd),
    .startGame  (startGame),
    .eoc        (eoc),
    .moveSpeed  (moveSpeed),
    .adc_start  (adc_start),
    .player     (player),
    .squareX    (squareX),
    .leftScore  (leftScore),
    .rightScore (rightScore),
    .gameOver   (gameOver),
    .winner     (winner),
    .busy       (busy)
  );

  function automatic void check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cycle, act, exp);
    end
  endfunction

  function automatic void fail_wait(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d: wait budget expired, got no event, expected one", nm, cycle);
  endfunction

  function automatic void model_reset();
    m_phase = P_IDLE; m_elapsed = 0; m_x = CENTER; m_player = 0;
    m_ls = 0; m_rs = 0; m_over = 0; m_win = 0; m_adc = 0;
    m_prev = 0; m_armed = 0; m_sample = 0;
  endfunction

  function automatic void start_conversion();
    m_phase = P_PULSE; m_elapsed = 0; m_adc = 1;
  endfunction

  // Game rules applied once per clock with the inputs seen at that edge.
  function automatic void model_step();
    int nx;
    int stp;
    bit rise;
    rise = startGame && (m_prev == 0) && (m_armed != 0);
    if (!startGame) m_armed = 1;
    m_prev = int'(startGame);
    if (m_phase != P_IDLE && !startGame) begin
      m_phase = P_IDLE;
      m_adc = 0;
      return;
    end
    case (m_phase)
      P_IDLE: if (rise) begin
        m_ls = 0; m_rs = 0; m_x = CENTER; m_player = 0; m_over = 0; m_win = 0;
        start_conversion();
      end
      P_PULSE: begin
        m_elapsed++;
        if (m_elapsed == START_PULSE) begin
          m_adc = 0; m_phase = P_WAIT; m_elapsed = 0;
        end
      end
      P_WAIT: begin
        if (eoc) begin
          m_sample = int'(moveSpeed);
          m_phase = P_FRAME;
        end else begin
          m_elapsed++;
          if (m_elapsed == EOC_TIMEOUT) start_conversion();
        end
      end
      P_FRAME: if (screenEnd) begin
        stp = m_sample / (1 << SHIFT);
        nx = (m_player == 0) ? m_x + stp : m_x - stp;
        if (nx > X_MAX) nx = X_MAX;
        if (nx < 0) nx = 0;
        m_player = 1 - m_player;
        if (nx < LEFT_LIM) begin
          nx = CENTER; m_rs++;
        end else if (nx > RIGHT_LIM) begin
          nx = CENTER; m_ls++;
        end
        m_x = nx;
        if (m_ls == MAX_SCORE || m_rs == MAX_SCORE) begin
          m_over = 1;
          m_win = (m_rs == MAX_SCORE) ? 1 : 0;
          m_phase = P_OVER;
        end else begin
          start_conversion();
        end
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("adc_start", int'(adc_start), m_adc);
      check("player", int'(player), m_player);
      check("squareX", int'(squareX), m_x);
      check("leftScore", int'(leftScore), m_ls);
      check("rightScore", int'(rightScore), m_rs);
      check("gameOver", int'(gameOver), m_over);
      check("winner", int'(winner), m_win);
      check("busy", int'(busy), (m_phase != P_IDLE) ? 1 : 0);
    end
  end

  task automatic wait_phase(input int ph, input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (m_phase == ph) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail_wait(nm);
  endtask

  // One complete move: conversion result spd, then a frame strobe.
  task automatic do_move(input logic [7:0] spd);
    bit ok;
    wait_phase(P_WAIT, "do_move_wait_eoc", ok);
    if (ok) begin
      moveSpeed = spd;
      eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
      screenEnd = 1'b1;
      @(negedge clk);
      screenEnd = 1'b0;
    end
  endtask

  task automatic new_game();
    startGame = 1'b0;
    @(negedge clk);
    startGame = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n_hi;
    int n_busy;
    int per;
    bit prev;
    bit got;
    bit ok;
    int bias;

    model_reset();
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_squareX", int'(squareX), 270);
    check("rst_adc_start", int'(adc_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_scores", int'(leftScore) + int'(rightScore), 0);
    reset = 1'b1;
    @(negedge clk);

    // first move: pulse width, eoc after 20 cycles, step 128>>5 = 4
    startGame = 1'b1;
    moveSpeed = 8'd128;
    n_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (adc_start) n_hi++;
    end
    check("pulse_width", n_hi, 11);
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_move_x", int'(squareX), 270);
    screenEnd = 1'b1;
    @(negedge clk);
    screenEnd = 1'b0;
    check("move_x", int'(squareX), 274);
    check("move_player", int'(player), 1);

    // eoc never arrives: start pulse repeats every 11+4096 cycles
    for (int r = 0; r < 2; r++) begin
      prev = adc_start;
      per = 0;
      got = 1'b0;
      for (int i = 1; i <= 5000; i++) begin
        @(negedge clk);
        if (adc_start && !prev) begin
          per = i;
          got = 1'b1;
          break;
        end
        prev = adc_start;
      end
      if (!got) fail_wait("retry_rise");
      else check("retry_period", per, 4107);
    end
    check("retry_x_held", int'(squareX), 274);

    // startGame drops together with screenEnd: stop wins, no move
    wait_phase(P_WAIT, "drop_wait_eoc", ok);
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    screenEnd = 1'b1;
    startGame = 1'b0;
    @(negedge clk);
    screenEnd = 1'b0;
    check("drop_busy", int'(busy), 0);
    check("drop_x", int'(squareX), 274);
    check("drop_player", int'(player), 1);

    // asynchronous reset in the middle of the start pulse
    startGame = 1'b1;
    repeat (5) @(negedge clk);
    check("pulse_c5_adc", int'(adc_start), 1);
    #1 reset = 1'b0;
    #1;
    check("async_adc", int'(adc_start), 0);
    check("async_busy", int'(busy), 0);
    check("async_x", int'(squareX), 270);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_hi = 0;
    n_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (adc_start) n_hi++;
      if (busy) n_busy++;
    end
    check("held_start_adc", n_hi, 0);
    check("held_start_busy", n_busy, 0);

    // walk left to 162 with player 1 to move, then step 7 scores for right
    new_game();
    for (int p = 0; p < 15; p++) begin
      do_move(8'd0);
      do_move(8'd255);
    end
    do_move(8'd0);
    do_move(8'd96);
    do_move(8'd0);
    check("pre_score_x", int'(squareX), 162);
    check("pre_score_player", int'(player), 1);
    do_move(8'd255);
    check("rscore", int'(rightScore), 1);
    check("rscore_x", int'(squareX), 270);
    check("rscore_player", int'(player), 0);

    // left player wins: +7 / -0 until leftScore reaches 9
    new_game();
    for (int k = 0; k < 600 && m_ls < 8; k++) do_move((m_player == 0) ? 8'd255 : 8'd0);
    check("lscore8", int'(leftScore), 8);
    check("lscore8_over", int'(gameOver), 0);
    for (int k = 0; k < 100 && m_over == 0; k++) do_move((m_player == 0) ? 8'd255 : 8'd0);
    check("win_lscore", int'(leftScore), 9);
    check("win_over", int'(gameOver), 1);
    check("win_winner", int'(winner), 0);
    n_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (adc_start) n_hi++;
    end
    check("over_adc_quiet", n_hi, 0);
    startGame = 1'b0;
    @(negedge clk);
    check("over_idle_busy", int'(busy), 0);
    check("over_hold", int'(gameOver), 1);
    check("over_hold_score", int'(leftScore), 9);

    // randomized play with biased or uniform players
    bias = 2;
    for (int c = 0; c < 40000; c++) begin
      @(negedge clk);
      eoc = ($urandom_range(0, 3) == 0);
      screenEnd = ($urandom_range(0, 4) == 0);
      if (m_phase == P_PULSE) begin
        if (bias == 2) moveSpeed = 8'($urandom_range(0, 255));
        else if ((m_player == 0) == (bias == 0)) moveSpeed = 8'($urandom_range(192, 255));
        else moveSpeed = 8'($urandom_range(0, 127));
      end
      if (!startGame) begin
        if ($urandom_range(0, 7) == 0) begin
          startGame = 1'b1;
          bias = int'($urandom_range(0, 2));
        end
      end else if (m_phase == P_OVER) begin
        if ($urandom_range(0, 19) == 0) startGame = 1'b0;
      end else if ($urandom_range(0, 2999) == 0) begin
        startGame = 1'b0;
      end
    end
    eoc = 1'b0;
    screenEnd = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
